// File: rtl/async_fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing the write port of one async FIFO.
// A packet is granted only when the FIFO reports at least MAXPKT free words.
module async_fifo_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DSIZE  = 8,
    parameter int MAXPKT = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_wfull,
    input  logic [7:0]            fifo_avail,
    output logic                  fifo_winc,
    output logic [DSIZE-1:0]      fifo_wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [15:0]           pkt_count
);
    localparam int              PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      AVAIL_MIN = 8'(MAXPKT);
    localparam logic [PW-1:0]   LAST_RST  = PW'(NREQ - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   last_ptr_q, last_ptr_d;
    logic [15:0]     pkt_count_q, pkt_count_d;

    logic [NREQ-1:0]  win_oh_s;
    logic             found_s;
    logic [PW-1:0]    cand_s;
    logic [PW-1:0]    gnt_idx_s;
    logic [DSIZE-1:0] gnt_data_s;
    logic             gnt_last_s;
    logic             beat_s;

    // Round-robin winner: first valid requester after the previous packet owner.
    always_comb begin
        win_oh_s = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = PW'((int'(last_ptr_q) + k) % NREQ);
            if (!found_s && req_valid[cand_s]) begin
                win_oh_s[cand_s] = 1'b1;
                found_s          = 1'b1;
            end else begin
                win_oh_s[cand_s] = win_oh_s[cand_s] & found_s;
            end
        end
    end

    // Decode the one-hot grant into an index and select the owner's data/last.
    always_comb begin
        gnt_idx_s  = '0;
        gnt_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_idx_s  = gnt_idx_s | (grant_q[i] ? PW'(i) : PW'(0));
            gnt_data_s = gnt_data_s | (req_data[i*DSIZE +: DSIZE] & {DSIZE{grant_q[i]}});
        end
        gnt_last_s = |(grant_q & req_last);
        beat_s     = (state_q == XFER) & (|(grant_q & req_valid)) & ~fifo_wfull;
    end

    // State register: FSM state, packet owner, round-robin pointer, packet counter.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_ptr_q  <= LAST_RST;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_ptr_q  <= last_ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, release the grant on the last accepted beat.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_ptr_d  = last_ptr_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if ((|req_valid) && (fifo_avail >= AVAIL_MIN)) begin
                    state_d = XFER;
                    grant_d = win_oh_s;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            XFER: begin
                // A lost grant would otherwise wedge the port forever.
                if (grant_q == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (beat_s && gnt_last_s) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    last_ptr_d  = gnt_idx_s;
                    pkt_count_d = pkt_count_q + 16'd1;
                end else begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: the owner's handshake is steered straight onto the FIFO port.
    always_comb begin
        busy      = 1'b0;
        req_ready = '0;
        fifo_winc = 1'b0;
        fifo_wdata = '0;
        case (state_q)
            XFER: begin
                busy       = 1'b1;
                req_ready  = grant_q & {NREQ{~fifo_wfull}};
                fifo_winc  = beat_s;
                fifo_wdata = gnt_data_s;
            end
            IDLE: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter: directed scenarios plus a randomized
// run, all cross-checked every cycle against a packet-level round-robin reference model.
module tb_async_fifo_wr_arbiter;
    localparam int NREQ   = 4;
    localparam int DSIZE  = 8;
    localparam int MAXPKT = 4;

    logic                  wclk       = 1'b0;
    logic                  wrst_n     = 1'b0;
    logic [NREQ-1:0]       req_valid  = '0;
    logic [NREQ-1:0]       req_last   = '0;
    logic [NREQ*DSIZE-1:0] req_data   = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wfull = 1'b0;
    logic [7:0]            fifo_avail = 8'd16;
    logic                  fifo_winc;
    logic [DSIZE-1:0]      fifo_wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [15:0]           pkt_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current packet owner (-1 = none), previous owner, packets done.
    int          m_owner = -1;
    int          m_last  = NREQ - 1;
    logic [15:0] m_cnt   = 16'd0;

    always #5 wclk = ~wclk;

    async_fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXPKT(MAXPKT)) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_avail (fifo_avail),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        rr_pick = -1;
        for (int k = NREQ; k >= 1; k--) begin
            if (v[(last + k) % NREQ]) rr_pick = (last + k) % NREQ;
        end
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        oh = '0;
        if (i >= 0) oh[i] = 1'b1;
    endfunction

    function automatic logic [DSIZE-1:0] word_of(input logic [NREQ*DSIZE-1:0] d, input int i);
        word_of = d[i*DSIZE +: DSIZE];
    endfunction

    // Reference model update: whole-packet grants, released on the accepted last beat.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_owner <= -1;
            m_last  <= NREQ - 1;
            m_cnt   <= 16'd0;
        end else if (m_owner < 0) begin
            if ((|req_valid) && (int'(fifo_avail) >= MAXPKT)) m_owner <= rr_pick(req_valid, m_last);
        end else if (req_valid[m_owner] && !fifo_wfull && req_last[m_owner]) begin
            m_last  <= m_owner;
            m_owner <= -1;
            m_cnt   <= m_cnt + 16'd1;
        end
    end

    // Per-cycle monitor: DUT outputs against the model, plus the structural invariants.
    always @(negedge wclk) begin
        logic [NREQ-1:0]  e_grant;
        logic [NREQ-1:0]  e_ready;
        logic             e_winc;
        logic [DSIZE-1:0] e_data;
        e_grant = oh(m_owner);
        e_ready = fifo_wfull ? '0 : e_grant;
        e_winc  = (m_owner >= 0) && req_valid[m_owner] && !fifo_wfull;
        e_data  = (m_owner >= 0) ? word_of(req_data, m_owner) : '0;
        n_cmp += 9;
        if (grant !== e_grant) begin n_err++; $display("FAIL mon_grant t=%0t got %b exp %b", $time, grant, e_grant); end
        if (busy !== (m_owner >= 0)) begin n_err++; $display("FAIL mon_busy t=%0t got %b exp %b", $time, busy, (m_owner >= 0)); end
        if (req_ready !== e_ready) begin n_err++; $display("FAIL mon_ready t=%0t got %b exp %b", $time, req_ready, e_ready); end
        if (fifo_winc !== e_winc) begin n_err++; $display("FAIL mon_winc t=%0t got %b exp %b", $time, fifo_winc, e_winc); end
        if (fifo_wdata !== e_data) begin n_err++; $display("FAIL mon_wdata t=%0t got %h exp %h", $time, fifo_wdata, e_data); end
        if (pkt_count !== m_cnt) begin n_err++; $display("FAIL mon_pkt_count t=%0t got %0d exp %0d", $time, pkt_count, m_cnt); end
        if (!$onehot0(grant)) begin n_err++; $display("FAIL inv_onehot t=%0t got %b exp onehot0", $time, grant); end
        if (fifo_winc && fifo_wfull) begin n_err++; $display("FAIL inv_winc_wfull t=%0t got winc=1 exp winc=0 while full", $time); end
        if ((req_ready & ~grant) !== '0) begin n_err++; $display("FAIL inv_ready_grant t=%0t got %b exp subset of %b", $time, req_ready, grant); end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [DSIZE-1:0] v);
        req_data[i*DSIZE +: DSIZE] = v;
    endtask

    task automatic do_reset();
        wrst_n     = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        fifo_wfull = 1'b0;
        fifo_avail = 8'd16;
        tick();
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n     = 1'b0;
        req_valid  = 4'b1111;
        req_last   = 4'b1111;
        req_data   = 32'hDDCC_BBAA;
        fifo_avail = 8'd16;
        tick();
        tick();
        n_cmp += 6;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b exp 0000", grant); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        if (fifo_winc !== 1'b0) begin n_err++; $display("FAIL reset_winc got %b exp 0", fifo_winc); end
        if (fifo_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata got %h exp 00", fifo_wdata); end
        if (pkt_count !== 16'd0) begin n_err++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
        wrst_n = 1'b1;
        tick();
        n_cmp += 2;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL reset_first_winner got %b exp 0001", grant); end
        if (fifo_wdata !== 8'hAA) begin n_err++; $display("FAIL reset_first_data got %h exp aa", fifo_wdata); end
    endtask

    task automatic test_single_packet();
        logic [DSIZE-1:0] d [3];
        d[0] = 8'h5A; d[1] = 8'hC3; d[2] = 8'h0F;
        do_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        set_word(1, d[0]);
        #1;
        n_cmp += 1;
        if (fifo_winc !== 1'b0) begin n_err++; $display("FAIL single_no_idle_write got %b exp 0", fifo_winc); end
        tick();
        n_cmp += 1;
        if (grant !== 4'b0010) begin n_err++; $display("FAIL single_grant got %b exp 0010", grant); end
        for (int b = 0; b < 3; b++) begin
            set_word(1, d[b]);
            req_last[1] = (b == 2);
            #1;
            n_cmp += 2;
            if (fifo_winc !== 1'b1) begin n_err++; $display("FAIL single_winc beat%0d got %b exp 1", b, fifo_winc); end
            if (fifo_wdata !== d[b]) begin n_err++; $display("FAIL single_wdata beat%0d got %h exp %h", b, fifo_wdata, d[b]); end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        n_cmp += 3;
        if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b exp 0", busy); end
        if (grant !== 4'b0000) begin n_err++; $display("FAIL single_idle_grant got %b exp 0000", grant); end
        if (pkt_count !== 16'd1) begin n_err++; $display("FAIL single_pkt_count got %0d exp 1", pkt_count); end
    endtask

    task automatic test_round_robin();
        int   n_beats;
        logic prev_winc;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_word(i, 8'hA0 + 8'(i));
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        n_beats   = 0;
        prev_winc = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (fifo_winc) begin
                n_cmp += 3;
                if (grant !== oh(n_beats % NREQ)) begin n_err++; $display("FAIL rr_order pkt%0d got %b exp %b", n_beats, grant, oh(n_beats % NREQ)); end
                if (fifo_wdata !== 8'hA0 + 8'(n_beats % NREQ)) begin n_err++; $display("FAIL rr_wdata pkt%0d got %h exp %h", n_beats, fifo_wdata, 8'hA0 + 8'(n_beats % NREQ)); end
                if (prev_winc !== 1'b0) begin n_err++; $display("FAIL rr_gap pkt%0d got back-to-back exp idle gap", n_beats); end
                n_beats++;
            end
            prev_winc = fifo_winc;
        end
        n_cmp += 2;
        if (n_beats != 8) begin n_err++; $display("FAIL rr_beats got %0d exp 8", n_beats); end
        if (pkt_count !== 16'd8) begin n_err++; $display("FAIL rr_pkt_count got %0d exp 8", pkt_count); end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_avail_gate();
        do_reset();
        fifo_avail = 8'd3;
        req_valid  = 4'b0100;
        req_last   = 4'b0100;
        set_word(2, 8'h77);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp += 2;
            if (grant !== 4'b0000) begin n_err++; $display("FAIL gate_no_grant c%0d got %b exp 0000", c, grant); end
            if (fifo_winc !== 1'b0) begin n_err++; $display("FAIL gate_no_winc c%0d got %b exp 0", c, fifo_winc); end
        end
        fifo_avail = 8'd4;
        tick();
        n_cmp += 2;
        if (grant !== 4'b0100) begin n_err++; $display("FAIL gate_grant got %b exp 0100", grant); end
        if (fifo_wdata !== 8'h77) begin n_err++; $display("FAIL gate_wdata got %h exp 77", fifo_wdata); end
        tick();
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_wfull_stall();
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        set_word(0, 8'h10);
        tick();
        n_cmp += 1;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL stall_grant got %b exp 0001", grant); end
        for (int b = 0; b < 4; b++) begin
            set_word(0, 8'h10 + 8'(b));
            req_last[0] = (b == 3);
            if (b == 2) begin
                fifo_wfull = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    n_cmp += 3;
                    if (fifo_winc !== 1'b0) begin n_err++; $display("FAIL stall_winc s%0d got %b exp 0", s, fifo_winc); end
                    if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready s%0d got %b exp 0000", s, req_ready); end
                    if (grant !== 4'b0001) begin n_err++; $display("FAIL stall_hold s%0d got %b exp 0001", s, grant); end
                    tick();
                end
                fifo_wfull = 1'b0;
            end
            #1;
            n_cmp += 3;
            if (fifo_winc !== 1'b1) begin n_err++; $display("FAIL stall_beat_winc b%0d got %b exp 1", b, fifo_winc); end
            if (fifo_wdata !== 8'h10 + 8'(b)) begin n_err++; $display("FAIL stall_beat_data b%0d got %h exp %h", b, fifo_wdata, 8'h10 + 8'(b)); end
            if (req_ready !== 4'b0001) begin n_err++; $display("FAIL stall_beat_ready b%0d got %b exp 0001", b, req_ready); end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_err++; $display("FAIL stall_done_busy got %b exp 0", busy); end
        if (pkt_count !== 16'd1) begin n_err++; $display("FAIL stall_pkt_count got %0d exp 1", pkt_count); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        set_word(3, 8'h30);
        tick();
        n_cmp += 1;
        if (grant !== 4'b1000) begin n_err++; $display("FAIL rstmid_grant got %b exp 1000", grant); end
        tick();
        set_word(3, 8'h31);
        #1;
        n_cmp += 1;
        if (fifo_winc !== 1'b1) begin n_err++; $display("FAIL rstmid_beat2 got %b exp 1", fifo_winc); end
        #1;
        wrst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL rstmid_grant_clr got %b exp 0000", grant); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        if (fifo_winc !== 1'b0) begin n_err++; $display("FAIL rstmid_winc got %b exp 0", fifo_winc); end
        if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_ready got %b exp 0000", req_ready); end
        if (pkt_count !== 16'd0) begin n_err++; $display("FAIL rstmid_pkt_count got %0d exp 0", pkt_count); end
        tick();
        wrst_n    = 1'b1;
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        set_word(0, 8'h40);
        tick();
        n_cmp += 2;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL rstmid_rearb got %b exp 0001", grant); end
        if (fifo_wdata !== 8'h40) begin n_err++; $display("FAIL rstmid_rearb_data got %h exp 40", fifo_wdata); end
        tick();
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_valid_bubble();
        do_reset();
        req_valid = 4'b0110;
        req_last  = 4'b0100;
        set_word(1, 8'h20);
        set_word(2, 8'h55);
        tick();
        n_cmp += 1;
        if (grant !== 4'b0010) begin n_err++; $display("FAIL bubble_grant got %b exp 0010", grant); end
        for (int b = 0; b < 4; b++) begin
            set_word(1, 8'h20 + 8'(b));
            req_last[1] = (b == 3);
            if (b == 1) begin
                req_valid[1] = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    #1;
                    n_cmp += 2;
                    if (fifo_winc !== 1'b0) begin n_err++; $display("FAIL bubble_gap_winc s%0d got %b exp 0", s, fifo_winc); end
                    if (grant !== 4'b0010) begin n_err++; $display("FAIL bubble_gap_grant s%0d got %b exp 0010", s, grant); end
                    tick();
                end
                req_valid[1] = 1'b1;
            end
            #1;
            n_cmp += 3;
            if (fifo_winc !== 1'b1) begin n_err++; $display("FAIL bubble_beat_winc b%0d got %b exp 1", b, fifo_winc); end
            if (fifo_wdata !== 8'h20 + 8'(b)) begin n_err++; $display("FAIL bubble_beat_data b%0d got %h exp %h", b, fifo_wdata, 8'h20 + 8'(b)); end
            if (grant !== 4'b0010) begin n_err++; $display("FAIL bubble_beat_grant b%0d got %b exp 0010", b, grant); end
            tick();
        end
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        #1;
        n_cmp += 1;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL bubble_release got %b exp 0000", grant); end
        tick();
        n_cmp += 2;
        if (grant !== 4'b0100) begin n_err++; $display("FAIL bubble_next_grant got %b exp 0100", grant); end
        if (fifo_wdata !== 8'h55) begin n_err++; $display("FAIL bubble_next_data got %h exp 55", fifo_wdata); end
        tick();
        req_valid = '0;
        req_last  = '0;
        #1;
        n_cmp += 1;
        if (pkt_count !== 16'd2) begin n_err++; $display("FAIL bubble_pkt_count got %0d exp 2", pkt_count); end
    endtask

    task automatic test_random();
        int               rem  [NREQ];
        logic [DSIZE-1:0] word [NREQ];
        logic             acc  [NREQ];
        int               sent;
        do_reset();
        sent = 0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0) begin
                    rem[i]  = int'($urandom_range(1, 6));
                    word[i] = 8'($urandom);
                end
                req_valid[i] = ($urandom_range(0, 9) < 7);
                req_last[i]  = (rem[i] == 1);
                set_word(i, word[i]);
            end
            fifo_wfull = ($urandom_range(0, 9) < 2);
            fifo_avail = 8'($urandom_range(0, 12));
            #1;
            for (int i = 0; i < NREQ; i++) acc[i] = (m_owner == i) && req_valid[i] && !fifo_wfull;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    if (rem[i] == 1) sent++;
                    rem[i]--;
                    word[i] = 8'($urandom);
                end
            end
        end
        n_cmp += 1;
        if (pkt_count !== 16'(sent)) begin n_err++; $display("FAIL rand_pkt_count got %0d exp %0d", pkt_count, sent); end
        req_valid = '0;
        req_last  = '0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_avail_gate();
        test_wfull_stall();
        test_reset_mid_packet();
        test_valid_bubble();
        test_random();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
- Shares the write port of one dual-clock async FIFO among NREQ packet producers, all in the wclk domain.
- Grants whole packets (req_last delimits them) using round-robin.
- Gates each grant on FIFO free space, so a packet normally lands without stalling.
- Honours wfull backpressure beat-by-beat. Sits directly in front of the FIFO's winc/wdata/wfull/avail interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data word width; must equal the FIFO DSIZE.
- MAXPKT, 4, minimum fifo_avail (words) required before a grant is issued.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester word valid.
- req_last  in  NREQ  per-requester last word of packet.
- req_data  in  NREQ*DSIZE  per-requester data; requester i uses bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester word accepted this cycle when valid&ready.
- fifo_wfull  in  1  FIFO full flag.
- fifo_avail  in  8  FIFO free words.
- fifo_winc  out  1  FIFO write strobe.
- fifo_wdata  out  DSIZE  FIFO write data.
- grant  out  NREQ  one-hot owner of the current packet; 0 when idle.
- busy  out  1  high in XFER.
- pkt_count  out  16  packets completed since reset; wraps modulo 2^16.

Behaviour:
- States: IDLE, XFER. Registers: state, grant, last_ptr (log2 NREQ bits), pkt_count.
- Reset (async, wrst_n=0): state=IDLE, grant=0, last_ptr=NREQ-1 (requester 0 wins first), pkt_count=0. Outputs during reset: busy=0, req_ready=0, fifo_winc=0, fifo_wdata=0.
- IDLE → XFER:
  - Condition: |req_valid && fifo_avail >= MAXPKT.
  - Winner: first requester with req_valid set, searching last_ptr+1, last_ptr+2, … modulo NREQ.
  - grant register loads the one-hot winner at the clock edge.
  - IDLE → XFER takes 1 cycle; no data moves in IDLE.
- IDLE with fifo_avail < MAXPKT: remain in IDLE and issue no grant, even when requests are pending.
- XFER, with g = granted index (all combinational):
  - req_ready[g] = ~fifo_wfull; req_ready of all other requesters = 0.
  - fifo_winc = req_valid[g] & ~fifo_wfull.
  - fifo_wdata = req_data[g]; all zero outside XFER.
- Accepted beat: fifo_winc=1. req_valid[g] low mid-packet inserts a bubble; the grant is held.
- Accepted beat with req_last[g]=1, at the next edge:
  - state=IDLE, grant=0.
  - last_ptr=g.
  - pkt_count += 1.
- Packet gap: at least 1 idle cycle between consecutive packets (arbitration bubble). Peak throughput for L-word packets is L/(L+1).
- Single-word packet (last on first beat): legal, completes in one XFER cycle.
- Packets longer than MAXPKT: legal; excess beats wait on fifo_wfull.
- Changes to other requesters' req_valid during XFER have no effect on the grant.
- fifo_wfull=1 in XFER: no write, no req_ready, state held, indefinitely.
- Reset mid-packet: abandon immediately, return to reset values. The partial packet already written stays in the FIFO; the FIFO side is reset by its own resets.
- Assertions for the bench:
  - grant is one-hot or zero.
  - fifo_winc implies ~fifo_wfull.
  - req_ready is never high for a non-granted requester.

Test Plan:
- Single requester 1 sends 3-word packet D0,D1,D2 (last on D2), avail=16, wfull=0 → grant=0010 one cycle after valid; fifo_winc high 3 consecutive cycles carrying D0,D1,D2; then IDLE; pkt_count=1.
- All 4 requesters continuously send 1-word packets from reset → grant order 0,1,2,3,0,1…; each winc separated by one idle cycle; pkt_count=8 after 16 cycles.
- Requester 2 valid, avail=3 (MAXPKT=4) for 5 cycles, then avail=4 → no grant while avail=3; grant=0100 the cycle after avail reaches 4.
- Requester 0 in a 4-word packet, wfull asserted for 3 cycles after beat 2 → winc=0 and req_ready=0 during stall; beats 3,4 written after release, order preserved; grant held throughout.
- wrst_n pulsed low mid-packet (requester 3 granted, beat 2 of 4) → grant=0, busy=0, winc=0 immediately; pkt_count=0; next arbitration with requesters 0 and 3 valid picks 0.
- Requester 1 drops req_valid for 2 cycles mid-packet while requester 2 is valid → no winc during gap, grant stays 0010; requester 2 granted only after requester 1's last beat.
